eth_phy_10g_tx_ipg_mux: RTL

Multi-channel IPG payload inserter for the 10G PHY TX path. It sits between the 64b/66b encoder output and the TX SERDES interface/scrambler. It replaces eligible all-idle control blocks with payload blocks drawn from N_CH valid/ready sources, arbitrated round-robin. Insertion happens only inside the inter-packet gap, never over frame or ordered-set blocks, and only after a configurable number of preserved idles.

---
 rtl/eth_ipg_pkg.sv | 15 +
 rtl/eth_phy_10g_tx_ipg_mux_rr_arbiter.sv | 48 ++++
 rtl/eth_phy_10g_tx_ipg_mux.sv | 125 ++++++++++++
 3 files changed

// File: rtl/eth_ipg_pkg.sv
// Shared constants for the 10G TX IPG payload inserter: sync headers,
// idle block type, payload width and the grant-index width helper.
package eth_ipg_pkg;

  localparam logic [1:0] SYNC_DATA       = 2'b10;
  localparam logic [1:0] SYNC_CTRL       = 2'b01;
  localparam logic [7:0] BLOCK_TYPE_IDLE = 8'h1e;
  localparam int         IPG_PAYLOAD_W   = 56;

  // Grant index width; a single channel still needs one bit.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eth_phy_10g_tx_ipg_mux_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above rr_ptr
// (wrapping), and moves rr_ptr past the winner when the grant is consumed.
module ipg_rr_arbiter
  import eth_ipg_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          req,
  input  logic                     advance,
  output logic [grant_w(N_CH)-1:0] grant_idx,
  output logic                     grant_valid
);

  localparam int GW = grant_w(N_CH);

  logic [GW-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      int            j;
      logic [GW-1:0] cand;
      j = int'(rr_ptr_q) + k;
      if (j >= N_CH) j = j - N_CH;
      cand = GW'(j);
      if (!grant_valid && req[cand]) begin
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance && grant_valid) begin
      rr_ptr_d = (grant_idx == GW'(N_CH - 1)) ? '0 : grant_idx + GW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/eth_phy_10g_tx_ipg_mux.sv
// Replaces eligible idle control blocks in the 10G TX stream with payload
// blocks from N_CH round-robin sources. Optional counters: ETH_IPG_MUX_STATS_EN.
module eth_phy_10g_tx_ipg_mux
  import eth_ipg_pkg::*;
#(
  parameter int         DATA_WIDTH     = 64,
  parameter int         HDR_WIDTH      = 2,
  parameter int         N_CH           = 4,
  parameter int         MIN_IDLE_KEEP  = 1,
  parameter logic [7:0] IPG_BLOCK_TYPE = 8'h1e
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         enc_tx_data,
  input  logic [HDR_WIDTH-1:0]          enc_tx_hdr,
  input  logic [N_CH*IPG_PAYLOAD_W-1:0] ipg_data,
  input  logic [N_CH-1:0]               ipg_valid,
  output logic [N_CH-1:0]               ipg_ready,
  output logic [DATA_WIDTH-1:0]         out_tx_data,
  output logic [HDR_WIDTH-1:0]          out_tx_hdr,
  output logic                          ipg_inserted,
  output logic [grant_w(N_CH)-1:0]      ipg_grant_ch
`ifdef ETH_IPG_MUX_STATS_EN
  ,
  output logic [N_CH*32-1:0]            ipg_insert_count,
  output logic [31:0]                   ipg_starve_count
`endif
);

  localparam int         GW   = grant_w(N_CH);
  localparam logic [3:0] KEEP = 4'(MIN_IDLE_KEEP);

  logic                     is_idle, eligible, transfer, grant_valid;
  logic [GW-1:0]            grant_idx;
  logic [3:0]               idle_run_q, idle_run_d;
  logic [IPG_PAYLOAD_W-1:0] payload_sel;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [HDR_WIDTH-1:0]     hdr_q, hdr_d;
  logic                     ins_q, ins_d;
  logic [GW-1:0]            ch_q, ch_d;

  ipg_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (ipg_valid),
    .advance     (transfer),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // idle_run is sampled before this block updates it; it saturates at KEEP.
  always_comb begin
    is_idle  = (enc_tx_hdr == SYNC_CTRL) &&
               (enc_tx_data[7:0] == BLOCK_TYPE_IDLE) &&
               (enc_tx_data[DATA_WIDTH-1:8] == '0);
    eligible = is_idle && (idle_run_q >= KEEP);
    transfer = eligible && grant_valid && !rst;

    idle_run_d = idle_run_q;
    if (!is_idle)               idle_run_d = '0;
    else if (idle_run_q < KEEP) idle_run_d = idle_run_q + 4'd1;

    ipg_ready = '0;
    if (transfer) ipg_ready[grant_idx] = 1'b1;

    payload_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_idx == GW'(i)) payload_sel = ipg_data[i*IPG_PAYLOAD_W +: IPG_PAYLOAD_W];
    end

    data_d = enc_tx_data;
    hdr_d  = enc_tx_hdr;
    ins_d  = 1'b0;
    ch_d   = '0;
    if (transfer) begin
      data_d = {payload_sel, IPG_BLOCK_TYPE};
      hdr_d  = SYNC_CTRL;
      ins_d  = 1'b1;
      ch_d   = grant_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_run_q <= KEEP;
      data_q     <= DATA_WIDTH'(BLOCK_TYPE_IDLE);
      hdr_q      <= SYNC_CTRL;
      ins_q      <= 1'b0;
      ch_q       <= '0;
    end else begin
      idle_run_q <= idle_run_d;
      data_q     <= data_d;
      hdr_q      <= hdr_d;
      ins_q      <= ins_d;
      ch_q       <= ch_d;
    end
  end

  assign out_tx_data  = data_q;
  assign out_tx_hdr   = hdr_q;
  assign ipg_inserted = ins_q;
  assign ipg_grant_ch = ch_q;

`ifdef ETH_IPG_MUX_STATS_EN
  logic [N_CH*32-1:0] ins_cnt_q;
  logic [31:0]        starve_q;

  // Insert counters wrap; the starve counter sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ins_cnt_q <= '0;
      starve_q  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (transfer && grant_idx == GW'(i)) ins_cnt_q[i*32 +: 32] <= ins_cnt_q[i*32 +: 32] + 32'd1;
      end
      if (eligible && !grant_valid && starve_q != 32'hFFFF_FFFF) starve_q <= starve_q + 32'd1;
    end
  end

  assign ipg_insert_count = ins_cnt_q;
  assign ipg_starve_count = starve_q;
`endif

endmodule
